// File: rtl/pipe_advance_ctrl.sv
//------------------------------------------------------------------------------
// Module      : pipe_advance_ctrl
// Description : IF/ID/EX/MEM/WB stage registers with advance/hold/bubble
//               control, saturating stall/retire counters and hazard watchdog.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pipe_advance_pkg;
  typedef struct packed {
    logic [3:0]  operation;
    logic [4:0]  rw;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [12:0] imm;
  } t_stage;

  localparam logic [3:0] c_op_nop = 4'h0;
  localparam logic [3:0] c_op_add = 4'h1;
  localparam logic [3:0] c_op_sub = 4'h2;
  localparam logic [3:0] c_op_and = 4'h3;
  localparam logic [3:0] c_op_alo = 4'h4;
  localparam logic [3:0] c_op_ahi = 4'h5;
  localparam logic [3:0] c_op_rdl = 4'h6;

  // Register fields of zero never match a hazard class, so a bubble is inert.
  localparam t_stage c_bubble = '{operation: c_op_nop, rw: 5'd0, r1: 5'd0,
                                  r2: 5'd0, imm: 13'd0};
endpackage

module pipe_advance_ctrl
  import pipe_advance_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int HAZ_MAX = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  t_stage           fetch_stage,
  input  logic             fetch_valid,
  input  logic             data_hazard,
  input  logic             mem_busy,
  output logic             fetch_ready,
  output t_stage           stage_if,
  output t_stage           stage_id,
  output t_stage           stage_ex,
  output t_stage           stage_mem,
  output t_stage           stage_wb,
  output logic             valid_if,
  output logic             valid_id,
  output logic             valid_ex,
  output logic             valid_mem,
  output logic             valid_wb,
  output logic [CNT_W-1:0] cnt_haz_stall,
  output logic [CNT_W-1:0] cnt_mem_stall,
  output logic [CNT_W-1:0] cnt_retired,
  output logic             haz_fault
);

  localparam int               c_run_w   = $clog2(HAZ_MAX + 2);
  localparam logic [c_run_w-1:0] c_run_max = c_run_w'(HAZ_MAX);
  localparam logic [c_run_w-1:0] c_run_one = c_run_w'(1);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  t_stage             r_stage_if, r_stage_id, r_stage_ex, r_stage_mem, r_stage_wb;
  logic               r_valid_if, r_valid_id, r_valid_ex, r_valid_mem, r_valid_wb;
  logic [CNT_W-1:0]   r_cnt_haz, r_cnt_mem, r_cnt_ret;
  logic [c_run_w-1:0] r_haz_run;
  logic               r_haz_fault;

  logic w_mem_stall;
  logic w_haz_stall;

  // mem_busy dominates: a hazard seen during a memory freeze is not a hazard cycle.
  assign w_mem_stall = mem_busy;
  assign w_haz_stall = data_hazard && !mem_busy;
  assign fetch_ready = rst_n && !mem_busy && !data_hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage_if  <= c_bubble;
      r_stage_id  <= c_bubble;
      r_stage_ex  <= c_bubble;
      r_stage_mem <= c_bubble;
      r_stage_wb  <= c_bubble;
      r_valid_if  <= 1'b0;
      r_valid_id  <= 1'b0;
      r_valid_ex  <= 1'b0;
      r_valid_mem <= 1'b0;
      r_valid_wb  <= 1'b0;
    end else if (w_mem_stall) begin
      r_stage_wb <= c_bubble;
      r_valid_wb <= 1'b0;
    end else if (w_haz_stall) begin
      r_stage_wb  <= r_stage_mem;
      r_valid_wb  <= r_valid_mem;
      r_stage_mem <= r_stage_ex;
      r_valid_mem <= r_valid_ex;
      r_stage_ex  <= r_stage_id;
      r_valid_ex  <= r_valid_id;
      r_stage_id  <= c_bubble;
      r_valid_id  <= 1'b0;
    end else begin
      r_stage_wb  <= r_stage_mem;
      r_valid_wb  <= r_valid_mem;
      r_stage_mem <= r_stage_ex;
      r_valid_mem <= r_valid_ex;
      r_stage_ex  <= r_stage_id;
      r_valid_ex  <= r_valid_id;
      r_stage_id  <= r_stage_if;
      r_valid_id  <= r_valid_if;
      r_stage_if  <= fetch_valid ? fetch_stage : c_bubble;
      r_valid_if  <= fetch_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_haz <= '0;
      r_cnt_mem <= '0;
      r_cnt_ret <= '0;
    end else begin
      if (r_valid_wb && (r_cnt_ret != c_cnt_max)) begin
        r_cnt_ret <= r_cnt_ret + c_cnt_one;
      end
      if (w_mem_stall && (r_cnt_mem != c_cnt_max)) begin
        r_cnt_mem <= r_cnt_mem + c_cnt_one;
      end
      if (w_haz_stall && (r_cnt_haz != c_cnt_max)) begin
        r_cnt_haz <= r_cnt_haz + c_cnt_one;
      end
    end
  end

  // Run length parks at HAZ_MAX; the cycle that would push it past sets the fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_haz_run   <= '0;
      r_haz_fault <= 1'b0;
    end else if (w_haz_stall) begin
      if (r_haz_run >= c_run_max) begin
        r_haz_fault <= 1'b1;
      end else begin
        r_haz_run <= r_haz_run + c_run_one;
      end
    end else if (!w_mem_stall) begin
      r_haz_run <= '0;
    end
  end

  assign stage_if      = r_stage_if;
  assign stage_id      = r_stage_id;
  assign stage_ex      = r_stage_ex;
  assign stage_mem     = r_stage_mem;
  assign stage_wb      = r_stage_wb;
  assign valid_if      = r_valid_if;
  assign valid_id      = r_valid_id;
  assign valid_ex      = r_valid_ex;
  assign valid_mem     = r_valid_mem;
  assign valid_wb      = r_valid_wb;
  assign cnt_haz_stall = r_cnt_haz;
  assign cnt_mem_stall = r_cnt_mem;
  assign cnt_retired   = r_cnt_ret;
  assign haz_fault     = r_haz_fault;

endmodule

`default_nettype wire

// File: tb/tb_pipe_advance_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_pipe_advance_ctrl
// Description : Directed self-checking bench for pipe_advance_ctrl.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_advance_ctrl;
  import pipe_advance_pkg::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  t_stage        fetch_stage;
  logic          fetch_valid;
  logic          data_hazard;
  logic          mem_busy;
  logic          fetch_ready;
  t_stage        stage_if, stage_id, stage_ex, stage_mem, stage_wb;
  logic          valid_if, valid_id, valid_ex, valid_mem, valid_wb;
  logic [CW-1:0] cnt_haz_stall, cnt_mem_stall, cnt_retired;
  logic          haz_fault;

  logic force_haz;
  logic use_det;
  logic w_det;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Reference hazard detector: IF reads a register written by ID or EX.
  assign w_det = valid_if &&
                 ((valid_id && (stage_id.rw != 5'd0) &&
                   ((stage_if.r1 == stage_id.rw) || (stage_if.r2 == stage_id.rw))) ||
                  (valid_ex && (stage_ex.rw != 5'd0) &&
                   ((stage_if.r1 == stage_ex.rw) || (stage_if.r2 == stage_ex.rw))));
  assign data_hazard = force_haz | (use_det & w_det);

  pipe_advance_ctrl #(.CNT_W(CW), .HAZ_MAX(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_stage  (fetch_stage),
    .fetch_valid  (fetch_valid),
    .data_hazard  (data_hazard),
    .mem_busy     (mem_busy),
    .fetch_ready  (fetch_ready),
    .stage_if     (stage_if),
    .stage_id     (stage_id),
    .stage_ex     (stage_ex),
    .stage_mem    (stage_mem),
    .stage_wb     (stage_wb),
    .valid_if     (valid_if),
    .valid_id     (valid_id),
    .valid_ex     (valid_ex),
    .valid_mem    (valid_mem),
    .valid_wb     (valid_wb),
    .cnt_haz_stall(cnt_haz_stall),
    .cnt_mem_stall(cnt_mem_stall),
    .cnt_retired  (cnt_retired),
    .haz_fault    (haz_fault)
  );

  function automatic t_stage mk(input logic [3:0] op, input logic [4:0] rw,
                                input logic [4:0] r1, input logic [4:0] r2);
    mk = '{operation: op, rw: rw, r1: r1, r2: r2, imm: 13'd0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input t_stage s);
    fetch_stage = s;
    fetch_valid = 1'b1;
  endtask

  task automatic do_reset();
    fetch_valid = 1'b0;
    mem_busy    = 1'b0;
    force_haz   = 1'b0;
    rst_n       = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  t_stage i_add, i_sub, i_and, i_alo, i_ahi, i_rdl, i_nul;

  initial begin
    rst_n       = 1'b0;
    fetch_stage = c_bubble;
    fetch_valid = 1'b0;
    mem_busy    = 1'b0;
    force_haz   = 1'b0;
    use_det     = 1'b1;

    // Reset state
    @(posedge clk);
    #1;
    chk("rst_valid", {valid_if, valid_id, valid_ex, valid_mem, valid_wb}, 5'b0);
    chk("rst_cnt", {cnt_haz_stall, cnt_mem_stall, cnt_retired}, '0);
    chk("rst_fault", haz_fault, 1'b0);
    chk("rst_fetch_ready", fetch_ready, 1'b0);
    chk("rst_wb_bubble", stage_wb, c_bubble);
    rst_n = 1'b1;

    // Independent stream
    i_add = mk(c_op_add, 5'd1, 5'd2, 5'd3);
    i_sub = mk(c_op_sub, 5'd4, 5'd5, 5'd6);
    i_and = mk(c_op_and, 5'd7, 5'd8, 5'd9);
    i_alo = mk(c_op_alo, 5'd10, 5'd11, 5'd0);
    i_ahi = mk(c_op_ahi, 5'd12, 5'd13, 5'd0);
    fetch(i_add); step();
    fetch(i_sub); step();
    fetch(i_and); step();
    fetch(i_alo); step();
    fetch(i_ahi); step();
    chk("s1_wb_add", stage_wb, i_add);
    chk("s1_valid_wb", valid_wb, 1'b1);
    chk("s1_if_ahi", stage_if, i_ahi);
    chk("s1_ret0", cnt_retired, 4'd0);
    fetch_valid = 1'b0;
    step();
    chk("s1_ret1", cnt_retired, 4'd1);
    chk("s1_wb_sub", stage_wb, i_sub);
    chk("s1_if_bubble", {valid_if, stage_if}, {1'b0, c_bubble});
    repeat (4) step();
    chk("s1_ret5", cnt_retired, 4'd5);
    chk("s1_wb_empty", valid_wb, 1'b0);
    chk("s1_haz0", cnt_haz_stall, 4'd0);
    chk("s1_fault0", haz_fault, 1'b0);

    // Load-use hazard resolved by the detector
    do_reset();
    i_alo = mk(c_op_alo, 5'd3, 5'd0, 5'd0);
    i_add = mk(c_op_add, 5'd4, 5'd3, 5'd1);
    fetch(i_alo); step();
    fetch(i_add); step();
    chk("s2_hazard_seen", data_hazard, 1'b1);
    chk("s2_fr_low1", fetch_ready, 1'b0);
    step();
    chk("s2_id_bubble1", {valid_id, stage_id}, {1'b0, c_bubble});
    chk("s2_ex_alo", stage_ex, i_alo);
    chk("s2_if_hold", stage_if, i_add);
    chk("s2_fr_low2", fetch_ready, 1'b0);
    step();
    chk("s2_id_bubble2", valid_id, 1'b0);
    chk("s2_mem_alo", stage_mem, i_alo);
    chk("s2_fr_high", fetch_ready, 1'b1);
    chk("s2_haz2", cnt_haz_stall, 4'd2);
    fetch_valid = 1'b0;
    step();
    chk("s2_id_add", {valid_id, stage_id}, {1'b1, i_add});
    chk("s2_haz_final", cnt_haz_stall, 4'd2);
    chk("s2_fault0", haz_fault, 1'b0);

    // Memory stall with RDL in MEM
    do_reset();
    i_rdl = mk(c_op_rdl, 5'd5, 5'd6, 5'd0);
    i_sub = mk(c_op_sub, 5'd7, 5'd8, 5'd9);
    i_and = mk(c_op_and, 5'd10, 5'd11, 5'd12);
    fetch(i_rdl); step();
    fetch(i_sub); step();
    fetch(i_and); step();
    fetch_valid = 1'b0;
    step();
    chk("s3_mem_rdl", stage_mem, i_rdl);
    mem_busy = 1'b1;
    #1;
    chk("s3_fr_busy", fetch_ready, 1'b0);
    step();
    chk("s3_wb_bubble1", valid_wb, 1'b0);
    step();
    step();
    chk("s3_mem_hold", stage_mem, i_rdl);
    chk("s3_ex_hold", stage_ex, i_sub);
    chk("s3_id_hold", stage_id, i_and);
    chk("s3_wb_bubble3", valid_wb, 1'b0);
    chk("s3_memstall3", cnt_mem_stall, 4'd3);
    mem_busy = 1'b0;
    step();
    chk("s3_wb_rdl", {valid_wb, stage_wb}, {1'b1, i_rdl});
    chk("s3_ret0", cnt_retired, 4'd0);
    step();
    chk("s3_ret1", cnt_retired, 4'd1);
    chk("s3_wb_sub", stage_wb, i_sub);
    step();
    chk("s3_ret2", cnt_retired, 4'd2);
    chk("s3_memstall_final", cnt_mem_stall, 4'd3);

    // Hazard and mem_busy together, then hazard alone
    do_reset();
    use_det = 1'b0;
    i_add = mk(c_op_add, 5'd1, 5'd2, 5'd3);
    i_sub = mk(c_op_sub, 5'd4, 5'd5, 5'd6);
    fetch(i_add); step();
    fetch(i_sub); step();
    fetch_valid = 1'b0;
    force_haz   = 1'b1;
    mem_busy    = 1'b1;
    step();
    step();
    chk("s4_id_hold", {valid_id, stage_id}, {1'b1, i_add});
    chk("s4_if_hold", stage_if, i_sub);
    chk("s4_mem2", cnt_mem_stall, 4'd2);
    chk("s4_haz0", cnt_haz_stall, 4'd0);
    mem_busy = 1'b0;
    step();
    chk("s4_id_bubble", valid_id, 1'b0);
    chk("s4_ex_add", stage_ex, i_add);
    chk("s4_if_still", stage_if, i_sub);
    chk("s4_haz1", cnt_haz_stall, 4'd1);
    chk("s4_mem_still2", cnt_mem_stall, 4'd2);
    force_haz = 1'b0;
    step();
    chk("s4_id_sub", stage_id, i_sub);
    chk("s4_fault0", haz_fault, 1'b0);

    // Watchdog: three unresolved hazard cycles
    do_reset();
    force_haz = 1'b1;
    step();
    step();
    chk("s5_fault_after2", haz_fault, 1'b0);
    step();
    chk("s5_fault_set", haz_fault, 1'b1);
    chk("s5_haz3", cnt_haz_stall, 4'd3);
    force_haz = 1'b0;
    step();
    step();
    chk("s5_fault_sticky", haz_fault, 1'b1);
    do_reset();
    chk("s5_fault_cleared", haz_fault, 1'b0);

    // Retire counter saturation, then reset during a stall
    use_det = 1'b1;
    i_nul = mk(c_op_add, 5'd0, 5'd0, 5'd0);
    fetch(i_nul);
    repeat (18) step();
    fetch_valid = 1'b0;
    step();
    step();
    chk("s6_ret15", cnt_retired, 4'd15);
    repeat (3) step();
    chk("s6_ret_sat", cnt_retired, 4'd15);
    chk("s6_wb_empty", valid_wb, 1'b0);
    fetch(i_nul);
    step();
    step();
    fetch_valid = 1'b0;
    mem_busy    = 1'b1;
    step();
    step();
    chk("s6_stall_id", {valid_if, valid_id}, 2'b11);
    chk("s6_mem2", cnt_mem_stall, 4'd2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("s6_async_valid", {valid_if, valid_id, valid_ex, valid_mem, valid_wb}, 5'b0);
    chk("s6_async_cnt", {cnt_haz_stall, cnt_mem_stall, cnt_retired}, '0);
    chk("s6_async_id", stage_id, c_bubble);
    chk("s6_async_fr", fetch_ready, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_advance_ctrl.md
Name: pipe_advance_ctrl

Overview:
- Owns the IF/ID/EX/MEM/WB stage registers of the five-stage core.
- Consumes the registered IF/ID/EX/MEM stage contents and the data_hazard flag they produce.
- Decides each cycle whether stages advance, hold, or take a bubble.
- Keeps saturating stall and retire counters for the cache-strategy experiments, and flags hazard-resolution faults.

Parameters:
- CNT_W, 32, width of every performance counter
- HAZ_MAX, 2, maximum consecutive unstalled hazard cycles before haz_fault sets

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- fetch_stage  in  t_stage  decoded instruction from fetch
- fetch_valid  in  1  fetch_stage holds a real instruction
- data_hazard  in  1  from hazard detector; combinational on stage_if/id/ex/mem
- mem_busy  in  1  MEM stage waiting on cache; freezes pipe
- fetch_ready  out  1  fetch may present next instruction (PC advance)
- stage_if, stage_id, stage_ex, stage_mem, stage_wb  out  t_stage  stage registers
- valid_if, valid_id, valid_ex, valid_mem, valid_wb  out  1  stage holds a real instruction
- cnt_haz_stall  out  CNT_W  cycles lost to data hazard
- cnt_mem_stall  out  CNT_W  cycles lost to mem_busy
- cnt_retired  out  CNT_W  valid instructions leaving WB
- haz_fault  out  1  sticky: hazard failed to resolve

Behaviour:
- Bubble definition:
  - operation = NOP (the no-op encoding in common.vh); r1 = r2 = rw = 0; valid = 0.
  - A bubble never matches any read or write class in the hazard detector.
- Reset (rst_n low, asynchronous):
  - All five stages = bubble, all valid_* = 0.
  - All counters = 0, haz_fault = 0.
  - Reset mid-stall discards in-flight instructions; no partial state survives.
- fetch_ready = rst_n && !mem_busy && !data_hazard. Combinational, no latency.
- Mode priority each rising edge: mem_busy > data_hazard > normal.
- Normal (neither asserted):
  - WB <- MEM, MEM <- EX, EX <- ID, ID <- IF.
  - IF <- fetch_stage with valid_if = fetch_valid, or a bubble when fetch_valid = 0.
- Hazard (data_hazard=1, mem_busy=0):
  - IF holds.
  - ID <- bubble.
  - EX <- ID, MEM <- EX, WB <- MEM.
  - fetch_stage is ignored (fetch_ready = 0).
- Mem stall (mem_busy=1, regardless of data_hazard):
  - IF, ID, EX, MEM hold.
  - WB <- bubble, so an instruction in WB retires exactly once.
- Counters, all saturating at 2^CNT_W-1 (no wrap):
  - cnt_retired += 1 on each edge where valid_wb=1, i.e. counted as the instruction leaves WB.
  - cnt_mem_stall += 1 per mem_busy cycle.
  - cnt_haz_stall += 1 per cycle in hazard mode; not counted when mem_busy also high.
- Hazard watchdog:
  - Internal counter haz_run increments per hazard-mode cycle.
  - haz_run is unchanged on mem-stall cycles and cleared on normal cycles.
  - When haz_run would exceed HAZ_MAX, haz_fault sets and stays set until reset.
  - With a correct detector, a hazard resolves within 2 bubbles, so haz_fault never sets.
- Stage contents pass through unmodified; no decoding happens in this block.
- Data hazard and mem_busy arrive in the same cycle they are evaluated; no internal pipelining of the control decision.

Test Plan:
- Reset then 5 fetches (ADD, SUB, AND, ALO, AHI) with independent registers and fetch_valid=1 -> ADD in WB at cycle 5; cnt_retired=1 at cycle 6; 0 hazard stalls; haz_fault=0.
- ALO r3 then ADD r4,r3,r1 back-to-back (detector model in loop) -> 2 hazard cycles; ID bubbles in cycles 2 and 3; ADD reaches ID at cycle 4; cnt_haz_stall=2; fetch_ready low for exactly 2 cycles.
- mem_busy high 3 cycles while RDL is in MEM -> IF..MEM frozen; WB bubble for 3 cycles; RDL retired once; cnt_mem_stall=3.
- data_hazard and mem_busy high together for 2 cycles, then hazard-only 1 cycle -> cnt_mem_stall=2, cnt_haz_stall=1; ID bubble inserted only in the hazard-only cycle.
- Force data_hazard=1 for 3 consecutive cycles with mem_busy=0 -> haz_fault sets on the 3rd edge and remains 1 after the hazard drops, until rst_n pulse.
- Preload cnt_retired near saturation (CNT_W=4, 15 retires, then 3 more) -> counter holds at 15; rst_n low mid-stall -> all valids 0 and counters 0 immediately, asynchronously.
